// File: rtl/sram_port_arbiter.sv
// Shared-port front end for the delay-line SRAM: independent read and write channels,
// each arbitrating N_PORTS requesters. Define SRAM_ARB_FIXED_PRIORITY_EN for fixed priority.
module sram_port_arbiter #(
   parameter int N_PORTS = 4,
   parameter int ADDR_W  = 14,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 15
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [N_PORTS-1:0]          rd_req,
   input  logic [N_PORTS*ADDR_W-1:0]   rd_addr,
   output logic [N_PORTS-1:0]          rd_ack,
   output logic                        rd_err,
   output logic [DATA_W-1:0]           rd_data,
   input  logic [N_PORTS-1:0]          wr_req,
   input  logic [N_PORTS*ADDR_W-1:0]   wr_addr,
   input  logic [N_PORTS*DATA_W-1:0]   wr_data,
   output logic [N_PORTS-1:0]          wr_ack,
   output logic                        wr_err,
   output logic                        mem_read,
   output logic [ADDR_W-1:0]           mem_read_addr,
   input  logic [DATA_W-1:0]           mem_data_out,
   input  logic                        mem_read_ready,
   input  logic                        mem_invalid_read,
   output logic                        mem_write,
   output logic [ADDR_W-1:0]           mem_write_addr,
   output logic [DATA_W-1:0]           mem_data_in,
   input  logic                        mem_write_ready,
   input  logic                        mem_invalid_write
);
   // state | meaning
   // IDLE  | waiting for a request while memory is ready; picks and latches winner
   // ISSUE | strobe high for one cycle, watchdog loaded
   // WAIT  | waiting for invalid pulse, ready low->high, or watchdog expiry
   // GAP   | one quiet cycle covering the memory's post-completion busy cycle
   localparam int IW = $clog2(N_PORTS);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

   // Channel 0 is read, channel 1 is write; the FSMs are identical.
   for (genvar c = 0; c < 2; c++) begin : g_ch
      localparam bit IS_RD = (c == 0);

      logic [N_PORTS-1:0]        req;
      logic [N_PORTS*ADDR_W-1:0] req_addr;
      logic [N_PORTS*DATA_W-1:0] req_data;
      logic                      mem_ready;
      logic                      mem_invalid;

      state_t                    state, state_nxt;
      logic [IW-1:0]             win, idx_q;
      logic                      any_req, grant, ack_ok, ack_bad;
      logic                      seen_low, strobe, err;
      logic [ADDR_W-1:0]         sel_addr, addr_q;
      logic [DATA_W-1:0]         sel_data, data_q;
      logic [N_PORTS-1:0]        ack;
      logic [TW-1:0]             wdog;

      assign req         = IS_RD ? rd_req : wr_req;
      assign req_addr    = IS_RD ? rd_addr : wr_addr;
      assign req_data    = IS_RD ? '0 : wr_data;
      assign mem_ready   = IS_RD ? mem_read_ready : mem_write_ready;
      assign mem_invalid = IS_RD ? mem_invalid_read : mem_invalid_write;

`ifdef SRAM_ARB_FIXED_PRIORITY_EN
      always_comb begin
         win     = '0;
         any_req = 1'b0;
         for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (req[i]) begin
               win     = IW'(i);
               any_req = 1'b1;
            end
         end
      end
`else
      logic [IW-1:0] rr_ptr;
      logic [IW-1:0] cand;

      // Scan downward so the candidate closest to the pointer is the last one written.
      always_comb begin
         win     = '0;
         any_req = 1'b0;
         cand    = '0;
         for (int i = N_PORTS - 1; i >= 0; i--) begin
            cand = IW'((int'(rr_ptr) + i) % N_PORTS);
            if (req[cand]) begin
               win     = cand;
               any_req = 1'b1;
            end
         end
      end

      always_ff @(posedge clk) begin
         if (reset)
            rr_ptr <= '0;
         else if (grant)
            rr_ptr <= (win == IW'(N_PORTS - 1)) ? '0 : win + IW'(1);
      end
`endif

      always_comb begin
         sel_addr = '0;
         sel_data = '0;
         for (int i = 0; i < N_PORTS; i++) begin
            if (win == IW'(i)) begin
               sel_addr = req_addr[i*ADDR_W +: ADDR_W];
               sel_data = req_data[i*DATA_W +: DATA_W];
            end
         end
      end

      always_ff @(posedge clk) begin
         if (reset)
            state <= IDLE;
         else
            state <= state_nxt;
      end

      always_comb begin
         state_nxt = state;
         grant     = 1'b0;
         ack_ok    = 1'b0;
         ack_bad   = 1'b0;
         case (state)
            IDLE: begin
               if (any_req && mem_ready) begin
                  grant     = 1'b1;
                  state_nxt = ISSUE;
               end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
               if (mem_invalid)
                  ack_bad = 1'b1;
               else if (seen_low && mem_ready)
                  ack_ok = 1'b1;
               else if (wdog == TW'(1))
                  ack_bad = 1'b1;
               if (ack_ok || ack_bad)
                  state_nxt = GAP;
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            idx_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            strobe   <= 1'b0;
            ack      <= '0;
            err      <= 1'b0;
            seen_low <= 1'b0;
            wdog     <= '0;
         end else begin
            strobe <= grant;
            ack    <= '0;
            err    <= 1'b0;
            if (grant) begin
               idx_q  <= win;
               addr_q <= sel_addr;
               data_q <= sel_data;
            end
            if (state == ISSUE) begin
               seen_low <= 1'b0;
               wdog     <= TW'(TIMEOUT);
            end
            if (state == WAIT) begin
               wdog <= wdog - TW'(1);
               if (!mem_ready)
                  seen_low <= 1'b1;
            end
            if (ack_ok || ack_bad) begin
               ack <= N_PORTS'(1) << idx_q;
               err <= ack_bad;
               if (ack_ok && IS_RD)
                  data_q <= mem_data_out;
            end
         end
      end
   end

   assign mem_read       = g_ch[0].strobe;
   assign mem_read_addr  = g_ch[0].addr_q;
   assign rd_ack         = g_ch[0].ack;
   assign rd_err         = g_ch[0].err;
   assign rd_data        = g_ch[0].data_q;
   assign mem_write      = g_ch[1].strobe;
   assign mem_write_addr = g_ch[1].addr_q;
   assign mem_data_in    = g_ch[1].data_q;
   assign wr_ack         = g_ch[1].ack;
   assign wr_err         = g_ch[1].err;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: behavioural SRAM with strobe/ready handshake and
// an ack scoreboard holding expected port, error flag, read data and ack cycle.
module tb_sram_port_arbiter;
   localparam int N  = 4;
   localparam int AW = 14;
   localparam int DW = 16;
   localparam int TO = 15;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    rd_req, wr_req;
   logic [N*AW-1:0] rd_addr, wr_addr;
   logic [N*DW-1:0] wr_data;
   logic [N-1:0]    rd_ack, wr_ack;
   logic            rd_err, wr_err;
   logic [DW-1:0]   rd_data;
   logic            mem_read, mem_write;
   logic [AW-1:0]   mem_read_addr, mem_write_addr;
   logic [DW-1:0]   mem_data_in;
   logic [DW-1:0]   mem_data_out      = '0;
   logic            mem_read_ready    = 1'b1;
   logic            mem_write_ready   = 1'b1;
   logic            mem_invalid_read  = 1'b0;
   logic            mem_invalid_write = 1'b0;

   sram_port_arbiter #(.N_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_err(rd_err), .rd_data(rd_data),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .wr_err(wr_err),
      .mem_read(mem_read), .mem_read_addr(mem_read_addr), .mem_data_out(mem_data_out),
      .mem_read_ready(mem_read_ready), .mem_invalid_read(mem_invalid_read),
      .mem_write(mem_write), .mem_write_addr(mem_write_addr), .mem_data_in(mem_data_in),
      .mem_write_ready(mem_write_ready), .mem_invalid_write(mem_invalid_write)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // 8K-word memory; addresses at or above 0x2000 are answered with an invalid pulse.
   logic [DW-1:0] mem [0:8191];
   logic [AW-1:0] rd_lat_addr = '0;
   int            rd_busy = 0;
   int            wr_busy = 0;
   bit            stall_rd;

   always @(posedge clk) begin
      mem_invalid_read <= 1'b0;
      if (mem_read) begin
         if (mem_read_addr >= 14'h2000)
            mem_invalid_read <= 1'b1;
         else begin
            mem_read_ready <= 1'b0;
            rd_busy        <= stall_rd ? 3 : 2;
            rd_lat_addr    <= mem_read_addr;
         end
      end else if (rd_busy == 3) begin
         if (!stall_rd) rd_busy <= 1;
      end else if (rd_busy == 2)
         rd_busy <= 1;
      else if (rd_busy == 1) begin
         rd_busy        <= 0;
         mem_read_ready <= 1'b1;
         mem_data_out   <= mem[rd_lat_addr[12:0]];
      end
   end

   always @(posedge clk) begin
      mem_invalid_write <= 1'b0;
      if (mem_write) begin
         if (mem_write_addr >= 14'h2000)
            mem_invalid_write <= 1'b1;
         else begin
            mem_write_ready <= 1'b0;
            wr_busy         <= 2;
            mem[mem_write_addr[12:0]] <= mem_data_in;
         end
      end else if (wr_busy == 2)
         wr_busy <= 1;
      else if (wr_busy == 1) begin
         wr_busy         <= 0;
         mem_write_ready <= 1'b1;
      end
   end

   typedef struct {int port; bit err; logic [DW-1:0] data; int cyc;} exp_t;
   exp_t rd_q[$];
   exp_t wr_q[$];
   exp_t em_r, em_w;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void push_rd(input int p, input bit e, input logic [DW-1:0] d, input int c);
      rd_q.push_back('{p, e, d, c});
   endfunction

   function automatic void push_wr(input int p, input bit e, input int c);
      wr_q.push_back('{p, e, '0, c});
   endfunction

   always @(negedge clk) begin
      if (!reset) begin
         if (rd_ack != '0) begin
            if (rd_q.size() == 0)
               chk("rd_spurious_ack", 32'(rd_ack), 0);
            else begin
               em_r = rd_q.pop_front();
               chk("rd_ack_port", 32'(rd_ack), 32'(1) << em_r.port);
               chk("rd_err", 32'(rd_err), 32'(em_r.err));
               if (!em_r.err) chk("rd_data", 32'(rd_data), 32'(em_r.data));
               chk("rd_ack_cycle", cyc, em_r.cyc);
            end
         end
         if (wr_ack != '0) begin
            if (wr_q.size() == 0)
               chk("wr_spurious_ack", 32'(wr_ack), 0);
            else begin
               em_w = wr_q.pop_front();
               chk("wr_ack_port", 32'(wr_ack), 32'(1) << em_w.port);
               chk("wr_err", 32'(wr_err), 32'(em_w.err));
               chk("wr_ack_cycle", cyc, em_w.cyc);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_drop(input bit is_rd, input int port, input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (is_rd ? rd_ack[port] : wr_ack[port]) seen = 1'b1;
      end
      chk(is_rd ? "rd_ack_seen" : "wr_ack_seen", 32'(seen), 1);
      if (is_rd) rd_req[port] = 1'b0;
      else       wr_req[port] = 1'b0;
   endtask

   task automatic rd_op(input int port, input logic [AW-1:0] a, input bit e,
                        input logic [DW-1:0] d, input int lat);
      @(negedge clk);
      rd_addr[port*AW +: AW] = a;
      rd_req[port] = 1'b1;
      push_rd(port, e, d, cyc + lat);
      wait_drop(1'b1, port, lat + 10);
   endtask

   int g;
   int p;

   initial begin
      reset = 1'b1; stall_rd = 1'b0;
      rd_req = '0; wr_req = '0; rd_addr = '0; wr_addr = '0; wr_data = '0;
      tick(3);
      chk("rst_rd_ack", 32'(rd_ack), 0);
      chk("rst_wr_ack", 32'(wr_ack), 0);
      chk("rst_rd_err", 32'(rd_err), 0);
      chk("rst_wr_err", 32'(wr_err), 0);
      chk("rst_rd_data", 32'(rd_data), 0);
      chk("rst_mem_read", 32'(mem_read), 0);
      chk("rst_mem_write", 32'(mem_write), 0);
      chk("rst_mem_read_addr", 32'(mem_read_addr), 0);
      chk("rst_mem_write_addr", 32'(mem_write_addr), 0);
      chk("rst_mem_data_in", 32'(mem_data_in), 0);
      reset = 1'b0;
      tick(2);

      // Preload 0x0123 = 0xBEEF through write port 3.
      wr_addr[3*AW +: AW] = 14'h0123;
      wr_data[3*DW +: DW] = 16'hBEEF;
      wr_req[3] = 1'b1;
      g = cyc;
      push_wr(3, 1'b0, g + 5);
      tick(1);
      chk("wr_strobe", 32'(mem_write), 1);
      chk("wr_strobe_addr", 32'(mem_write_addr), 32'h0123);
      chk("wr_strobe_data", 32'(mem_data_in), 32'hBEEF);
      wait_drop(1'b0, 3, 10);

      // Single read on port 2.
      tick(1);
      rd_addr[2*AW +: AW] = 14'h0123;
      rd_req[2] = 1'b1;
      g = cyc;
      push_rd(2, 1'b0, 16'hBEEF, g + 5);
      tick(1);
      chk("rd_strobe", 32'(mem_read), 1);
      chk("rd_strobe_addr", 32'(mem_read_addr), 32'h0123);
      wait_drop(1'b1, 2, 10);

      // All four ports write continuously; port 0 re-requests with new data after its first ack.
      tick(1);
      for (int k = 0; k < N; k++) begin
         wr_addr[k*AW +: AW] = 14'h0100 + 14'(k);
         wr_data[k*DW +: DW] = 16'hA000 + 16'(k);
      end
      wr_req = '1;
      g = cyc;
      for (int k = 0; k < N; k++) push_wr(k, 1'b0, g + 5 + 6 * k);
      push_wr(0, 1'b0, g + 29);
      for (int it = 0; it < 5; it++) begin
         p = -1;
         for (int t = 0; t < 20 && p < 0; t++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) if (wr_ack[k]) p = k;
         end
         chk("wr_stream_ack", 32'(p >= 0), 1);
         if (p < 0) break;
         if (it == 0) begin
            wr_addr[0 +: AW] = 14'h0200;
            wr_data[0 +: DW] = 16'h5A5A;
         end else
            wr_req[p] = 1'b0;
      end
      wr_req = '0;
      for (int k = 0; k < N; k++) rd_op(1, 14'h0100 + 14'(k), 1'b0, 16'hA000 + 16'(k), 5);
      rd_op(1, 14'h0200, 1'b0, 16'h5A5A, 5);

      // Concurrent read (port 0) and write (port 1).
      @(negedge clk);
      rd_addr[0 +: AW]    = 14'h0100;
      wr_addr[1*AW +: AW] = 14'h0300;
      wr_data[1*DW +: DW] = 16'h1234;
      rd_req[0] = 1'b1;
      wr_req[1] = 1'b1;
      g = cyc;
      push_rd(0, 1'b0, 16'hA000, g + 5);
      push_wr(1, 1'b0, g + 5);
      tick(1);
      chk("conc_mem_read", 32'(mem_read), 1);
      chk("conc_mem_write", 32'(mem_write), 1);
      tick(4);
      chk("conc_rd_ack", 32'(rd_ack), 32'b0001);
      chk("conc_wr_ack", 32'(wr_ack), 32'b0010);
      rd_req = '0;
      wr_req = '0;
      rd_op(2, 14'h0300, 1'b0, 16'h1234, 5);

      // Out-of-range read: invalid pulse, error ack two cycles after the strobe.
      rd_op(0, 14'h2000, 1'b1, 16'h0000, 3);

      // Memory never comes back: watchdog error, then normal service resumes.
      stall_rd = 1'b1;
      rd_op(1, 14'h0101, 1'b1, 16'h0000, TO + 2);
      stall_rd = 1'b0;
      tick(4);
      rd_op(1, 14'h0101, 1'b0, 16'hA001, 5);

      // Reset in the middle of an access: no ack, pointer back to port 0.
      @(negedge clk);
      rd_addr[2*AW +: AW] = 14'h0102;
      rd_req[2] = 1'b1;
      tick(3);
      reset = 1'b1;
      tick(2);
      chk("rstmid_mem_read", 32'(mem_read), 0);
      chk("rstmid_rd_ack", 32'(rd_ack), 0);
      rd_req = '0;
      reset = 1'b0;
      tick(4);
      chk("post_rst_rd_ack", 32'(rd_ack), 0);
      @(negedge clk);
      rd_addr[0 +: AW]    = 14'h0100;
      rd_addr[3*AW +: AW] = 14'h0103;
      rd_req[0] = 1'b1;
      rd_req[3] = 1'b1;
      g = cyc;
      push_rd(0, 1'b0, 16'hA000, g + 5);
      push_rd(3, 1'b0, 16'hA003, g + 11);
      wait_drop(1'b1, 0, 10);
      wait_drop(1'b1, 3, 10);

      tick(3);
      chk("scoreboard_empty", 32'(rd_q.size() + wr_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
